// File: rtl/lc3_pipeline_controller_if.sv
// Signal bundle between the LC3 pipeline controller (master) and the datapath (slave).
interface lc3_pipeline_controller_if;
    logic        complete_instr;
    logic        complete_data;
    logic [15:0] IR;
    logic [15:0] IR_Exec;
    logic [2:0]  NZP;
    logic [2:0]  psr;
    logic        enable_updatePC;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        br_taken;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic        bypass_mem_1;
    logic        bypass_mem_2;
    logic [1:0]  mem_state;

    modport master (
        input  complete_instr, complete_data, IR, IR_Exec, NZP, psr,
        output enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
               bypass_mem_1, bypass_mem_2, mem_state
    );

    modport slave (
        output complete_instr, complete_data, IR, IR_Exec, NZP, psr,
        input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
               bypass_mem_1, bypass_mem_2, mem_state
    );
endinterface

// File: rtl/lc3_pipeline_controller.sv
// Stage-enable sequencer for the LC3 five-stage pipe: fill, memory stalls, branch bubbles, bypass selects.
// Optional instruction-memory stall: define LC3_CTRL_IMEM_STALL_EN.
module lc3_pipeline_controller #(
    parameter int unsigned CTRL_BUBBLES = 3
) (
    input  logic                             clock,
    input  logic                             reset,
    lc3_pipeline_controller_if.master        bus
);
    localparam int unsigned CNT_W = 3;
    localparam int unsigned EN_W  = 5;

    // Enable vector order: {updatePC, fetch, decode, execute, writeback}
    localparam logic [EN_W-1:0] EN_NONE  = 5'b00000;
    localparam logic [EN_W-1:0] EN_FILL0 = 5'b11000;
    localparam logic [EN_W-1:0] EN_FILL1 = 5'b11100;
    localparam logic [EN_W-1:0] EN_FILL2 = 5'b11110;
    localparam logic [EN_W-1:0] EN_ALL   = 5'b11111;
    localparam logic [EN_W-1:0] EN_WB    = 5'b00001;

    localparam logic [1:0] MS_READ  = 2'd0;
    localparam logic [1:0] MS_IND   = 2'd1;
    localparam logic [1:0] MS_WRITE = 2'd2;
    localparam logic [1:0] MS_IDLE  = 2'd3;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;

    typedef enum logic [2:0] {FILL0, FILL1, FILL2, RUN, MEM, WB, BUBBLE} state_t;

    function automatic logic is_alu(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    state_t          state_q, state_d;
    logic [EN_W-1:0] en_q, en_d;
    logic            br_q, br_d;
    logic [1:0]      ms_q, ms_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            load_q, load_d;

    logic [3:0] op_e, op_d;
    logic       taken_c;
    logic       imem_stall_c;

    assign op_e    = bus.IR_Exec[15:12];
    assign op_d    = bus.IR[15:12];
    assign taken_c = (op_e == OP_JMP) || ((op_e == OP_BR) && (|(bus.NZP & bus.psr)));

`ifdef LC3_CTRL_IMEM_STALL_EN
    assign imem_stall_c = ~bus.complete_instr;
`else
    assign imem_stall_c = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FILL0;
            en_q    <= EN_NONE;
            br_q    <= 1'b0;
            ms_q    <= MS_IDLE;
            cnt_q   <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            br_q    <= br_d;
            ms_q    <= ms_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
        end
    end

    // Next state plus next registered outputs; enables default to off every cycle.
    always_comb begin
        state_d = state_q;
        en_d    = EN_NONE;
        br_d    = 1'b0;
        ms_d    = ms_q;
        cnt_d   = cnt_q;
        load_d  = load_q;

        if (imem_stall_c && (state_q inside {FILL0, FILL1, FILL2, RUN})) begin
            en_d = EN_NONE;
        end else begin
            case (state_q)
                FILL0: begin
                    en_d    = EN_FILL0;
                    state_d = FILL1;
                end
                FILL1: begin
                    en_d    = EN_FILL1;
                    state_d = FILL2;
                end
                FILL2: begin
                    en_d    = EN_FILL2;
                    state_d = RUN;
                end
                RUN: begin
                    if (is_load(op_e) || is_store(op_e)) begin
                        state_d = MEM;
                        load_d  = is_load(op_e);
                        if ((op_e == OP_LDI) || (op_e == OP_STI)) begin
                            ms_d = MS_IND;
                        end else begin
                            ms_d = is_load(op_e) ? MS_READ : MS_WRITE;
                        end
                    end else if (taken_c) begin
                        state_d = BUBBLE;
                        br_d    = 1'b1;
                        cnt_d   = CNT_W'(CTRL_BUBBLES - 1);
                    end else begin
                        en_d = EN_ALL;
                    end
                end
                MEM: begin
                    // The indirect pointer fetch is followed by the real data access.
                    if (bus.complete_data && (ms_q != MS_IDLE)) begin
                        if (ms_q == MS_IND) begin
                            ms_d = load_q ? MS_READ : MS_WRITE;
                        end else begin
                            ms_d = MS_IDLE;
                            if (load_q) begin
                                state_d = WB;
                                en_d    = EN_WB;
                            end else begin
                                state_d = RUN;
                                en_d    = EN_ALL;
                            end
                        end
                    end
                end
                WB: begin
                    state_d = RUN;
                    en_d    = EN_ALL;
                end
                BUBBLE: begin
                    if (cnt_q == '0) begin
                        state_d = RUN;
                        en_d    = EN_ALL;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = FILL0;
                end
            endcase
        end
    end

    logic       in_run_c;
    logic       leave_mem_c;
    logic       reads_sr1_c;
    logic       reads_sr2_c;
    logic [2:0] sr2_c;
    logic       hit1_c;
    logic       hit2_c;

    // Source-register match of the decoding instruction against the execute destination.
    always_comb begin
        reads_sr1_c = is_alu(op_d) || (op_d == OP_LDR) || (op_d == OP_STR) || (op_d == OP_JMP);
        reads_sr2_c = 1'b0;
        sr2_c       = bus.IR[2:0];
        if (is_store(op_d)) begin
            reads_sr2_c = 1'b1;
            sr2_c       = bus.IR[11:9];
        end else if (((op_d == OP_ADD) || (op_d == OP_AND)) && !bus.IR[5]) begin
            reads_sr2_c = 1'b1;
        end
        hit1_c = reads_sr1_c && (bus.IR_Exec[11:9] == bus.IR[8:6]);
        hit2_c = reads_sr2_c && (bus.IR_Exec[11:9] == sr2_c);
    end

    assign in_run_c    = (state_q == RUN);
    assign leave_mem_c = (state_q == MEM) && bus.complete_data &&
                         ((ms_q == MS_READ) || (ms_q == MS_WRITE));

    assign bus.bypass_alu_1 = in_run_c && is_alu(op_e) && hit1_c;
    assign bus.bypass_alu_2 = in_run_c && is_alu(op_e) && hit2_c;
    assign bus.bypass_mem_1 = leave_mem_c && is_load(op_e) && hit1_c;
    assign bus.bypass_mem_2 = leave_mem_c && is_load(op_e) && hit2_c;

    assign bus.enable_updatePC  = en_q[4];
    assign bus.enable_fetch     = en_q[3];
    assign bus.enable_decode    = en_q[2];
    assign bus.enable_execute   = en_q[1];
    assign bus.enable_writeback = en_q[0];
    assign bus.br_taken         = br_q;
    assign bus.mem_state        = ms_q;
endmodule

// File: tb/tb_lc3_pipeline_controller.sv
// Scoreboard bench for lc3_pipeline_controller: directed vectors, expected output words queued per cycle.
module tb_lc3_pipeline_controller;
    logic clock = 1'b0;
    logic reset;

    lc3_pipeline_controller_if bus ();

    lc3_pipeline_controller #(.CTRL_BUBBLES(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    // Output word: {updPC, fetch, decode, execute, writeback, br_taken, alu1, alu2, mem1, mem2, mem_state[1:0]}
    typedef struct {
        logic [11:0] v;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    localparam logic [4:0] NO  = 5'b00000;
    localparam logic [4:0] F0  = 5'b11000;
    localparam logic [4:0] F1  = 5'b11100;
    localparam logic [4:0] F2  = 5'b11110;
    localparam logic [4:0] ALL = 5'b11111;
    localparam logic [4:0] WBP = 5'b00001;

    localparam logic [15:0] NEUTRAL = 16'hE000;

    function automatic logic [11:0] ev(input logic [4:0] en, input logic br,
                                       input logic [3:0] byp, input logic [1:0] ms);
        return {en, br, byp, ms};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input logic [11:0] v, input string name);
        exp_t e;
        e.v    = v;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compares at every falling edge for which an expectation is queued.
    initial begin
        exp_t        e;
        logic [11:0] act;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode,
                       bus.enable_execute, bus.enable_writeback, bus.br_taken,
                       bus.bypass_alu_1, bus.bypass_alu_2, bus.bypass_mem_1,
                       bus.bypass_mem_2, bus.mem_state};
                vectors++;
                if (act !== e.v) begin
                    miscompares++;
                    $display("FAIL %s: got %b expected %b", e.name, act, e.v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        reset              = 1'b1;
        bus.complete_instr = 1'b1;
        bus.complete_data  = 1'b0;
        bus.IR             = NEUTRAL;
        bus.IR_Exec        = NEUTRAL;
        bus.NZP            = 3'b000;
        bus.psr            = 3'b000;

        // Reset and fill
        tick();                                    expect_out(ev(NO, 0, 4'b0000, 2'd3), "reset_c1");
        tick(); reset = 1'b0;                      expect_out(ev(NO, 0, 4'b0000, 2'd3), "reset_c2");
        tick();                                    expect_out(ev(F0, 0, 4'b0000, 2'd3), "fill0");
        tick();                                    expect_out(ev(F1, 0, 4'b0000, 2'd3), "fill1");
        tick();                                    expect_out(ev(F2, 0, 4'b0000, 2'd3), "fill2");
        tick();                                    expect_out(ev(ALL, 0, 4'b0000, 2'd3), "run");

        // ALU forwarding
        tick(); bus.IR_Exec = 16'h1261; bus.IR = 16'h1441;
        expect_out(ev(ALL, 0, 4'b1100, 2'd3), "alu_byp_both");
        tick(); bus.IR = 16'h1462;
        expect_out(ev(ALL, 0, 4'b1000, 2'd3), "alu_byp_imm");
        tick(); bus.IR = 16'h72C0;
        expect_out(ev(ALL, 0, 4'b0100, 2'd3), "alu_byp_store");

        // LD with three-cycle access and memory forwarding on exit
        tick(); bus.IR_Exec = 16'h2A05; bus.IR = 16'h1145;
        expect_out(ev(ALL, 0, 4'b0000, 2'd3), "ld_issue");
        tick();                                    expect_out(ev(NO, 0, 4'b0000, 2'd0), "ld_mem1");
        tick();                                    expect_out(ev(NO, 0, 4'b0000, 2'd0), "ld_mem2");
        tick(); bus.complete_data = 1'b1;          expect_out(ev(NO, 0, 4'b0011, 2'd0), "ld_mem3_byp");
        tick(); bus.complete_data = 1'b0; bus.IR_Exec = NEUTRAL; bus.IR = NEUTRAL;
        expect_out(ev(WBP, 0, 4'b0000, 2'd3), "ld_wb_pulse");
        tick();                                    expect_out(ev(ALL, 0, 4'b0000, 2'd3), "ld_resume");

        // STI: pointer read then data write
        tick(); bus.IR_Exec = 16'hBA05;            expect_out(ev(ALL, 0, 4'b0000, 2'd3), "sti_issue");
        tick();                                    expect_out(ev(NO, 0, 4'b0000, 2'd1), "sti_ind1");
        tick(); bus.complete_data = 1'b1;          expect_out(ev(NO, 0, 4'b0000, 2'd1), "sti_ind2");
        tick(); bus.complete_data = 1'b0;          expect_out(ev(NO, 0, 4'b0000, 2'd2), "sti_wr1");
        tick(); bus.complete_data = 1'b1;          expect_out(ev(NO, 0, 4'b0000, 2'd2), "sti_wr2");
        tick(); bus.complete_data = 1'b0; bus.IR_Exec = NEUTRAL;
        expect_out(ev(ALL, 0, 4'b0000, 2'd3), "sti_done_no_wb");
        tick(); bus.complete_data = 1'b1;          expect_out(ev(ALL, 0, 4'b0000, 2'd3), "idle_cd_a");
        tick(); bus.complete_data = 1'b0;          expect_out(ev(ALL, 0, 4'b0000, 2'd3), "idle_cd_b");

        // Taken BRz, with a dependent ALU pair presented during the bubbles
        tick(); bus.IR_Exec = 16'h0405; bus.NZP = 3'b010; bus.psr = 3'b010;
        expect_out(ev(ALL, 0, 4'b0000, 2'd3), "brz_issue");
        tick(); bus.IR_Exec = 16'h1261; bus.IR = 16'h1441;
        expect_out(ev(NO, 1, 4'b0000, 2'd3), "brz_taken");
        tick();                                    expect_out(ev(NO, 0, 4'b0000, 2'd3), "brz_bubble2");
        tick();                                    expect_out(ev(NO, 0, 4'b0000, 2'd3), "brz_bubble3");
        tick();                                    expect_out(ev(ALL, 0, 4'b1100, 2'd3), "brz_resume");

        // Untaken BRz
        tick(); bus.IR_Exec = 16'h0405; bus.psr = 3'b100; bus.IR = NEUTRAL;
        expect_out(ev(ALL, 0, 4'b0000, 2'd3), "brn_issue");
        tick(); bus.IR_Exec = NEUTRAL;             expect_out(ev(ALL, 0, 4'b0000, 2'd3), "brn_untaken");

        // JMP always taken
        tick(); bus.IR_Exec = 16'hC000;            expect_out(ev(ALL, 0, 4'b0000, 2'd3), "jmp_issue");
        tick(); bus.IR_Exec = NEUTRAL;             expect_out(ev(NO, 1, 4'b0000, 2'd3), "jmp_taken");
        tick();                                    expect_out(ev(NO, 0, 4'b0000, 2'd3), "jmp_bubble2");
        tick();                                    expect_out(ev(NO, 0, 4'b0000, 2'd3), "jmp_bubble3");
        tick();                                    expect_out(ev(ALL, 0, 4'b0000, 2'd3), "jmp_resume");

        // BR with NZP = 000 is never taken
        tick(); bus.IR_Exec = 16'h0005; bus.NZP = 3'b000; bus.psr = 3'b010;
        expect_out(ev(ALL, 0, 4'b0000, 2'd3), "br000_issue");
        tick(); bus.IR_Exec = NEUTRAL;             expect_out(ev(ALL, 0, 4'b0000, 2'd3), "br000_untaken");

        // Reset in the middle of an indirect access
        tick(); bus.IR_Exec = 16'hBA05;            expect_out(ev(ALL, 0, 4'b0000, 2'd3), "rst_sti_issue");
        tick(); reset = 1'b1;                      expect_out(ev(NO, 0, 4'b0000, 2'd1), "rst_sti_ind");
        tick(); reset = 1'b0; bus.IR_Exec = NEUTRAL;
        expect_out(ev(NO, 0, 4'b0000, 2'd3), "rst_abort");
        tick();                                    expect_out(ev(F0, 0, 4'b0000, 2'd3), "refill0");
        tick();                                    expect_out(ev(F1, 0, 4'b0000, 2'd3), "refill1");
        tick();                                    expect_out(ev(F2, 0, 4'b0000, 2'd3), "refill2");
        tick();                                    expect_out(ev(ALL, 0, 4'b0000, 2'd3), "rerun");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lc3_pipeline_controller.md
Name: lc3_pipeline_controller

Overview:
- Central sequencer for the LC3 five-stage datapath: fetch, decode, execute, writeback and PC update.
- Generates the per-stage enables, including the enable_decode strobe consumed by the decode stage.
- Stalls the pipe for data-memory accesses and control transfers, and raises ALU/memory bypass selects for back-to-back dependencies.
- Sits beside the datapath at the top level and is the only driver of the stage enables.

Parameters:
- CTRL_BUBBLES, 3: number of cycles fetch/decode are held after a control instruction enters execute (legal 1..7).

Ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- complete_instr  in  1  instruction memory returned valid data
- complete_data  in  1  data memory access finished
- IR  in  16  instruction at decode output / execute input
- IR_Exec  in  16  instruction currently in execute
- NZP  in  3  branch condition field from execute
- psr  in  3  current condition codes {N,Z,P}
- enable_updatePC  out  1  PC register load
- enable_fetch  out  1  fetch stage enable
- enable_decode  out  1  decode stage enable
- enable_execute  out  1  execute stage enable
- enable_writeback  out  1  register-file write enable
- br_taken  out  1  select branch target into PC
- bypass_alu_1  out  1  forward ALU result to source 1
- bypass_alu_2  out  1  forward ALU result to source 2
- bypass_mem_1  out  1  forward memory data to source 1
- bypass_mem_2  out  1  forward memory data to source 2
- mem_state  out  2  0 read, 1 indirect read, 2 write, 3 idle

Behaviour:
- Reset (sampled on posedge):
  - all enables, br_taken and bypass outputs = 0; mem_state = 3; FSM = FILL0.
  - Reset asserted in any state aborts immediately; there is no partial completion of memory access or bubble count.
- Fill:
  - FILL0: fetch + updatePC.
  - FILL1: also decode.
  - FILL2: also execute.
  - Next cycle enters RUN with all five enables = 1.
- Opcode decode uses IR_Exec[15:12] / IR[15:12]:
  - ALU = ADD 0001, AND 0101, NOT 1001
  - load = LD 0010, LDR 0110, LDI 1010
  - store = ST 0011, STR 0111, STI 1011
  - control = BR 0000, JMP 1100
- RUN, load/store in execute: next state MEM; all enables = 0.
  - LD/LDR: mem_state = 0.
  - ST/STR: mem_state = 2.
  - LDI/STI: mem_state = 1 until complete_data, then 0 (LDI) or 2 (STI) until a second complete_data.
  - On the final complete_data: mem_state = 3 next cycle. Loads pulse enable_writeback one cycle; then all enables resume (RUN).
  - complete_data while mem_state = 3 is ignored.
- RUN, control in execute:
  - br_taken = 1 for one cycle: BR when |(NZP & psr), JMP always.
  - Enter BUBBLE: fetch/decode/updatePC = 0 for CTRL_BUBBLES cycles, execute/writeback = 0; then RUN.
  - If br_taken was 0, updatePC still resumes normally; no bubbles are inserted for an untaken BR (NZP & psr == 0).
  - BR with NZP = 000 is treated as untaken.
- Simultaneous memory and control cases cannot occur (single execute slot). Memory takes priority if both opcode classes are somehow flagged.
- Bypass (combinational from IR/IR_Exec, forced 0 outside RUN):
  - bypass_alu_1: IR_Exec is ALU, IR reads SR1 (ALU, LDR, STR, JMP), and IR_Exec[11:9] == IR[8:6].
  - bypass_alu_2: IR_Exec is ALU, IR is ADD/AND with IR[5] = 0, and IR_Exec[11:9] == IR[2:0].
  - Store data source (ST/STR/STI) uses IR[11:9] as source 2 for the same comparison.
  - bypass_mem_1/2: same comparisons with IR_Exec a load, asserted only in the cycle leaving MEM.
- Latency:
  - enables registered, 1 cycle after the triggering state change.
  - br_taken registered.
  - mem_state registered.

Optional Feature:
- LC3_CTRL_IMEM_STALL_EN
  - Defined: in RUN/FILL, if complete_instr = 0 then enable_fetch, enable_updatePC and enable_decode are held 0 (execute/writeback also 0) until complete_instr = 1. No state advance.
  - Undefined: complete_instr is ignored; the port remains for connectivity.

Test Plan:
- Reset held 2 cycles, then released → enables rise in order fetch+updatePC, decode, execute, writeback on cycles 1–4; mem_state = 3 throughout.
- IR_Exec = 16'h2A05 (LD), complete_data after 3 cycles → mem_state = 0 for 3 cycles, all enables 0; enable_writeback pulses 1 cycle, then RUN.
- IR_Exec = 16'hBA05 (STI) → mem_state 1 until first complete_data, then 2 until second, then 3; no writeback pulse.
- IR_Exec = 16'h0405 (BRz), psr = 010 → br_taken = 1 one cycle, fetch/decode low 3 cycles. With psr = 100 → br_taken = 0, no bubbles.
- IR_Exec = 16'h1261 (ADD R1,R1,#1), IR = 16'h1441 (ADD R2,R1,R1) → bypass_alu_1 = 1 and bypass_alu_2 = 1.
- Reset asserted mid-MEM (mem_state = 1) → next cycle all outputs at reset values, FSM = FILL0.
